data_mem_responder: RTL and testbench

Responder end of the CPU data-memory interface. It accepts the core's stage-3 load/store requests (address, write data, transfer type, read/write enables) and returns load data combinationally in the same cycle, as the core's load path requires. Stores commit on the clock edge. The block also decodes a small memory-mapped I/O window: a cycle counter, a store counter, and a `tohost` mailbox. It detects misaligned, illegal-type and out-of-range accesses and holds them in a sticky fault record.

---
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_responder: data-memory responder with RAM, MMIO and fault trap  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_WR_out,
  input  logic [2:0]  MEM_type,
  input  logic        MEM_rd_en,
  input  logic        MEM_wr_en,
  output logic [31:0] MEM_data,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
);
  localparam int c_IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] r_ram [DEPTH_WORDS];
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_store_cnt;
  logic [31:0] r_fault_addr;
  logic [31:0] r_tohost_data;
  logic        r_fault;
  logic        r_tohost_valid;

  logic               w_sz_byte;
  logic               w_sz_half;
  logic               w_sz_word;
  logic               w_type_ok;
  logic               w_is_ram;
  logic               w_is_mmio;
  logic               w_misalign;
  logic               w_fault;
  logic               w_store;
  logic [31:0]        w_mmio_off;
  logic [31:0]        w_rword;
  logic [31:0]        w_rshift;
  logic [31:0]        w_mmio_rd;
  logic [c_IDX_W-1:0] w_idx;

  always_comb begin
    w_sz_byte  = (MEM_type[1:0] == 2'b00);
    w_sz_half  = (MEM_type[1:0] == 2'b01);
    w_sz_word  = (MEM_type == 3'b010);
    w_type_ok  = w_sz_byte || w_sz_half || w_sz_word;
    w_is_ram   = ((MEM_addr >> (c_IDX_W + 2)) == 32'd0);
    w_mmio_off = MEM_addr - MMIO_BASE;
    w_is_mmio  = (w_mmio_off < 32'd12);
    w_misalign = (w_sz_half && MEM_addr[0]) ||
                 (w_sz_word && (MEM_addr[1:0] != 2'b00));
    // Unsigned types are load-only; the MMIO window is word-only.
    w_fault    = (MEM_rd_en || MEM_wr_en) &&
                 ((MEM_rd_en && MEM_wr_en) || !w_type_ok || w_misalign ||
                  !(w_is_ram || w_is_mmio) || (w_is_mmio && !w_sz_word) ||
                  (MEM_wr_en && MEM_type[2]));
    w_store    = MEM_wr_en && !w_fault;
    w_idx      = MEM_addr[c_IDX_W+1:2];
    w_rword    = r_ram[w_idx];
    // Half accesses are aligned here, so the byte-granular shift also serves halves.
    w_rshift   = w_rword >> {MEM_addr[1:0], 3'b000};
  end

  always_comb begin
    w_mmio_rd = '0;
    case (w_mmio_off[3:2])
      2'd0:    w_mmio_rd = r_tohost_data;
      2'd1:    w_mmio_rd = r_cycle_cnt;
      2'd2:    w_mmio_rd = r_store_cnt;
      default: w_mmio_rd = '0;
    endcase
  end

  always_comb begin
    MEM_data = '0;
    if (MEM_rd_en && !w_fault) begin
      if (w_is_mmio)      MEM_data = w_mmio_rd;
      else if (w_sz_byte) MEM_data = w_rshift & 32'h0000_00FF;
      else if (w_sz_half) MEM_data = w_rshift & 32'h0000_FFFF;
      else                MEM_data = w_rword;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset && w_store && w_is_ram && !w_is_mmio) begin
      if (w_sz_word) begin
        r_ram[w_idx] <= MEM_WR_out;
      end else if (w_sz_half) begin
        if (MEM_addr[1]) r_ram[w_idx][31:16] <= MEM_WR_out[15:0];
        else             r_ram[w_idx][15:0]  <= MEM_WR_out[15:0];
      end else begin
        case (MEM_addr[1:0])
          2'd0:    r_ram[w_idx][7:0]   <= MEM_WR_out[7:0];
          2'd1:    r_ram[w_idx][15:8]  <= MEM_WR_out[7:0];
          2'd2:    r_ram[w_idx][23:16] <= MEM_WR_out[7:0];
          default: r_ram[w_idx][31:24] <= MEM_WR_out[7:0];
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_cycle_cnt    <= '0;
      r_store_cnt    <= '0;
      r_fault        <= 1'b0;
      r_fault_addr   <= '0;
      r_tohost_valid <= 1'b0;
      r_tohost_data  <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_fault) begin
        r_fault <= 1'b1;
        if (!r_fault) r_fault_addr <= MEM_addr;
      end
      if (w_store) r_store_cnt <= r_store_cnt + 32'd1;
      if (w_store && w_is_mmio && (w_mmio_off[3:2] == 2'd0)) begin
        r_tohost_valid <= 1'b1;
        r_tohost_data  <= MEM_WR_out;
      end
    end
  end

  assign fault        = r_fault;
  assign fault_addr   = r_fault_addr;
  assign tohost_valid = r_tohost_valid;
  assign tohost_data  = r_tohost_data;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_responder: vector table plus corner sequences, queue-checked |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_data_mem_responder;
  localparam logic [31:0] MB   = 32'hFFFF_0000;
  localparam logic [2:0]  T_B  = 3'b000;
  localparam logic [2:0]  T_H  = 3'b001;
  localparam logic [2:0]  T_W  = 3'b010;
  localparam logic [2:0]  T_BU = 3'b100;
  localparam logic [2:0]  T_HU = 3'b101;
  localparam logic [2:0]  T_X  = 3'b011;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] MEM_addr = '0;
  logic [31:0] MEM_WR_out = '0;
  logic [2:0]  MEM_type = '0;
  logic        MEM_rd_en = 1'b0;
  logic        MEM_wr_en = 1'b0;
  logic [31:0] MEM_data;
  logic        fault;
  logic [31:0] fault_addr;
  logic        tohost_valid;
  logic [31:0] tohost_data;

  data_mem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(MB)) dut (
    .CLK(CLK), .Reset(Reset), .MEM_addr(MEM_addr), .MEM_WR_out(MEM_WR_out),
    .MEM_type(MEM_type), .MEM_rd_en(MEM_rd_en), .MEM_wr_en(MEM_wr_en),
    .MEM_data(MEM_data), .fault(fault), .fault_addr(fault_addr),
    .tohost_valid(tohost_valid), .tohost_data(tohost_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  typ;
    logic        rd;
    logic        wr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                              input logic rd, input logic wr, input logic [31:0] e, input string n);
    vec_t v;
    v.addr = a; v.wd = d; v.typ = t; v.rd = rd; v.wr = wr; v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                       input logic rd, input logic wr, input logic [31:0] e, input string n);
    sb_t s;
    MEM_addr = a; MEM_WR_out = d; MEM_type = t; MEM_rd_en = rd; MEM_wr_en = wr;
    s.exp = e; s.name = n;
    sb.push_back(s);
  endtask

  task automatic sample();
    sb_t s;
    #1;
    s = sb.pop_front();
    check(s.name, MEM_data, s.exp);
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t,
                      input logic rd, input logic wr, input logic [31:0] e, input string n);
    @(negedge CLK);
    apply(a, d, t, rd, wr, e, n);
    sample();
  endtask

  task automatic idle();
    @(negedge CLK);
    MEM_rd_en = 1'b0; MEM_wr_en = 1'b0;
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back(mk(32'h10,   32'hDEADBEEF, T_W,  0, 1, 32'h0,        "st_w_10"));
    vecs.push_back(mk(32'h13,   32'h0,        T_B,  1, 0, 32'h0000_00DE, "ld_b_13"));
    vecs.push_back(mk(32'h12,   32'h0,        T_H,  1, 0, 32'h0000_DEAD, "ld_h_12"));
    vecs.push_back(mk(32'h10,   32'h0,        T_W,  1, 0, 32'hDEADBEEF, "ld_w_10"));
    vecs.push_back(mk(32'h10,   32'h0,        T_BU, 1, 0, 32'h0000_00EF, "ld_bu_10"));
    vecs.push_back(mk(32'h20,   32'h11223344, T_W,  0, 1, 32'h0,        "st_w_20"));
    vecs.push_back(mk(32'h20,   32'h0,        T_W,  1, 0, 32'h11223344, "ld_w_20_old"));
    vecs.push_back(mk(32'h21,   32'hFFFFFF5A, T_B,  0, 1, 32'h0,        "st_b_21"));
    vecs.push_back(mk(32'h20,   32'h0,        T_W,  1, 0, 32'h11225A44, "ld_w_20_merge"));
    vecs.push_back(mk(32'h22,   32'hFFFF1234, T_H,  0, 1, 32'h0,        "st_h_22"));
    vecs.push_back(mk(32'h22,   32'h0,        T_HU, 1, 0, 32'h0000_1234, "ld_hu_22"));
    vecs.push_back(mk(32'h40,   32'h01020304, T_W,  0, 1, 32'h0,        "st_w_40"));
    vecs.push_back(mk(32'h50,   32'h55667788, T_W,  0, 1, 32'h0,        "st_w_50"));
    vecs.push_back(mk(MB + 8,   32'h0,        T_W,  1, 0, 32'd6,        "store_cnt_6"));
    vecs.push_back(mk(MB,       32'h1,        T_W,  0, 1, 32'h0,        "st_tohost"));
    vecs.push_back(mk(MB,       32'h0,        T_W,  1, 0, 32'h1,        "ld_tohost"));
    vecs.push_back(mk(MB + 4,   32'hAAAA,     T_W,  0, 1, 32'h0,        "st_cycle_ign"));
    vecs.push_back(mk(MB + 8,   32'h0,        T_W,  1, 0, 32'd8,        "store_cnt_8"));
    vecs.push_back(mk(32'h52,   32'h0,        T_B,  1, 0, 32'h0000_0066, "ld_b_52"));

    // Reset state, then cycle counter read in the sixth cycle after release.
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
    check("rst_tohost_valid", {31'd0, tohost_valid}, 32'd0);
    check("rst_tohost_data", tohost_data, 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    repeat (4) idle();
    step(MB + 4, 32'h0, T_W, 1, 0, 32'd5, "cycle_cnt_6th");

    foreach (vecs[i]) step(vecs[i].addr, vecs[i].wd, vecs[i].typ, vecs[i].rd, vecs[i].wr,
                           vecs[i].exp, vecs[i].name);
    idle();
    check("no_fault_yet", {31'd0, fault}, 32'd0);
    check("tohost_valid", {31'd0, tohost_valid}, 32'd1);
    check("tohost_data", tohost_data, 32'd1);

    // Fault capture and suppression of side effects.
    step(32'h31, 32'h0, T_H, 1, 0, 32'h0, "ld_h_31_fault");
    idle();
    check("fault_set", {31'd0, fault}, 32'd1);
    check("fault_addr_31", fault_addr, 32'h31);
    step(32'h40, 32'hCAFEF00D, T_W, 1, 1, 32'h0, "both_en_40");
    idle();
    check("fault_addr_kept", fault_addr, 32'h31);
    step(32'h40, 32'h0, T_W, 1, 0, 32'h01020304, "ld_40_unchanged");
    step(MB, 32'h77, T_B, 0, 1, 32'h0, "st_b_mmio");
    idle();
    check("tohost_data_kept", tohost_data, 32'd1);
    step(32'h40, 32'hFF, T_BU, 0, 1, 32'h0, "st_bu_40");
    step(32'h40, 32'h0, T_W, 1, 0, 32'h01020304, "ld_40_after_bu");
    step(32'h1000, 32'h0, T_W, 1, 0, 32'h0, "ld_out_of_range");
    step(32'h10, 32'h0, T_X, 1, 0, 32'h0, "ld_illegal_type");
    step(32'h12, 32'h0, T_W, 1, 0, 32'h0, "ld_w_misaligned");
    step(MB + 12, 32'h0, T_W, 1, 0, 32'h0, "ld_past_mmio");
    step(MB + 4, 32'h0, T_H, 1, 0, 32'h0, "ld_h_mmio");
    step(MB + 8, 32'h0, T_W, 1, 0, 32'd8, "store_cnt_no_faults");

    // Cycle counter wrap.
    @(negedge CLK);
    force dut.r_cycle_cnt = 32'hFFFF_FFFF;
    apply(MB + 4, 32'h0, T_W, 1, 0, 32'hFFFF_FFFF, "cycle_cnt_max");
    sample();
    release dut.r_cycle_cnt;
    step(MB + 4, 32'h0, T_W, 1, 0, 32'h0, "cycle_cnt_wrap");

    // Reset asserted during a store: store dropped, status and counters cleared.
    @(negedge CLK);
    Reset = 1'b0;
    apply(32'h50, 32'hFFFF_FFFF, T_W, 0, 1, 32'h0, "st_in_reset");
    sample();
    step(32'h50, 32'h0, T_W, 1, 0, 32'h55667788, "ld_50_in_reset");
    check("rst2_fault", {31'd0, fault}, 32'd0);
    check("rst2_fault_addr", fault_addr, 32'd0);
    check("rst2_tohost_valid", {31'd0, tohost_valid}, 32'd0);
    check("rst2_tohost_data", tohost_data, 32'd0);
    @(negedge CLK);
    Reset = 1'b1;
    apply(MB + 4, 32'h0, T_W, 1, 0, 32'd0, "cycle_cnt_restart");
    sample();
    step(MB + 8, 32'h0, T_W, 1, 0, 32'd0, "store_cnt_restart");
    step(32'h50, 32'h0, T_W, 1, 0, 32'h55667788, "ld_50_after_reset");
    idle();

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
